// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler
//   Oversampling front end of the UART receiver. Counts clock edges within a
//   bit period and bit periods within a frame, takes three samples around
//   mid-bit, majority-votes them and strobes the result for one cycle.
//
// Ports
//   CLK            system clock, rising edge
//   RST            asynchronous active-low reset
//   RX_IN          serial line (already synchronised to CLK)
//   Prescale       requested oversampling ratio (8, 16 or 32)
//   edge_bit_en    from RX FSM: run the edge/bit counters
//   dat_sam_en     from RX FSM: enable mid-bit sampling
//   edge_count     clock edges elapsed within the current bit (0..P-1)
//   bit_count      bit periods completed in the current frame (saturates at 15)
//   sampled_bit    majority-voted value of the last sampled bit
//   sampling_done  one-cycle strobe qualifying sampled_bit
module uart_rx_sampler #(
    parameter int unsigned FALLBACK_PRESCALE = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic [5:0] Prescale,
    input  logic       edge_bit_en,
    input  logic       dat_sam_en,
    output logic [5:0] edge_count,
    output logic [3:0] bit_count,
    output logic       sampled_bit,
    output logic       sampling_done
);

    localparam logic [5:0] FALLBACK_P = 6'(FALLBACK_PRESCALE);

    function automatic logic prescale_legal(input logic [5:0] p);
        return (p == 6'd8) || (p == 6'd16) || (p == 6'd32);
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic [5:0] prescale_q, prescale_d;
    logic [5:0] edge_q,     edge_d;
    logic [3:0] bit_q,      bit_d;
    logic       s0_q,       s0_d;
    logic       s1_q,       s1_d;
    logic       sampled_q,  sampled_d;
    logic       done_q,     done_d;
    logic [5:0] half;

    assign half = prescale_q >> 1;

    always_comb begin
        // Ratio is only accepted between frames so a mid-frame change cannot
        // distort the bit period currently being counted.
        prescale_d = prescale_q;
        if (!edge_bit_en) begin
            prescale_d = prescale_legal(Prescale) ? Prescale : FALLBACK_P;
        end

        edge_d = 6'd0;
        bit_d  = 4'd0;
        if (edge_bit_en) begin
            if (edge_q == prescale_q - 6'd1) begin
                edge_d = 6'd0;
                bit_d  = (bit_q == 4'd15) ? bit_q : bit_q + 4'd1;
            end else begin
                edge_d = edge_q + 6'd1;
                bit_d  = bit_q;
            end
        end

        s0_d      = s0_q;
        s1_d      = s1_q;
        sampled_d = sampled_q;
        done_d    = 1'b0;
        if (!dat_sam_en) begin
            s0_d      = 1'b0;
            s1_d      = 1'b0;
            sampled_d = 1'b1;
        end else begin
            if (edge_q == half - 6'd1) s0_d = RX_IN;
            if (edge_q == half)        s1_d = RX_IN;
            // The third sample is RX_IN itself; a counter clear in the same
            // cycle suppresses the strobe.
            if (edge_bit_en && (edge_q == half + 6'd1)) begin
                sampled_d = majority3(s0_q, s1_q, RX_IN);
                done_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            prescale_q <= FALLBACK_P;
            edge_q     <= 6'd0;
            bit_q      <= 4'd0;
            s0_q       <= 1'b0;
            s1_q       <= 1'b0;
            sampled_q  <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            prescale_q <= prescale_d;
            edge_q     <= edge_d;
            bit_q      <= bit_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            sampled_q  <= sampled_d;
            done_q     <= done_d;
        end
    end

    assign edge_count    = edge_q;
    assign bit_count     = bit_q;
    assign sampled_bit   = sampled_q;
    assign sampling_done = done_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler
//   Directed bench for uart_rx_sampler. Inputs change 1 time unit after the
//   rising edge; outputs are read in the same window, so each loop iteration
//   corresponds to one clock cycle.
module tb_uart_rx_sampler;

    logic       CLK;
    logic       RST;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       edge_bit_en;
    logic       dat_sam_en;
    logic [5:0] edge_count;
    logic [3:0] bit_count;
    logic       sampled_bit;
    logic       sampling_done;

    int n_vec;
    int n_err;

    uart_rx_sampler #(.FALLBACK_PRESCALE(8)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_IN        (RX_IN),
        .Prescale     (Prescale),
        .edge_bit_en  (edge_bit_en),
        .dat_sam_en   (dat_sam_en),
        .edge_count   (edge_count),
        .bit_count    (bit_count),
        .sampled_bit  (sampled_bit),
        .sampling_done(sampling_done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One cycle with counters disabled so the next cycle starts a fresh frame
    // and the given prescale is latched.
    task automatic start_frame(input logic [5:0] p, input logic dse);
        Prescale    = p;
        edge_bit_en = 1'b0;
        dat_sam_en  = dse;
        tick();
        edge_bit_en = 1'b1;
    endtask

    logic frame_bits [0:10];
    logic rx_exp;

    initial begin
        n_vec = 0;
        n_err = 0;
        RST = 1'b1; RX_IN = 1'b1; Prescale = 6'd8; edge_bit_en = 1'b0; dat_sam_en = 1'b0;

        // Reset values before any clock edge
        #2 RST = 1'b0;
        #1;
        check("rst_edge",    edge_count,    0);
        check("rst_bit",     bit_count,     0);
        check("rst_sampled", sampled_bit,   1);
        check("rst_done",    sampling_done, 0);
        #10 RST = 1'b1;
        tick(); tick();

        // Frame 0xA5 at P=8: start, LSB-first data, even parity 0, stop
        frame_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        start_frame(6'd8, 1'b1);
        for (int c = 0; c < 88; c++) begin
            RX_IN = frame_bits[c / 8];
            check("frm_edge", edge_count, c % 8);
            check("frm_bit",  bit_count,  c / 8);
            check("frm_done", sampling_done, (c % 8 == 6) ? 1 : 0);
            if (c % 8 == 6) check("frm_sampled", sampled_bit, frame_bits[c / 8]);
            tick();
        end
        check("frm_bit_end",  bit_count,  11);
        check("frm_edge_end", edge_count, 0);

        // Reset asserted mid-frame at edge_count=5, bit_count=3
        RX_IN = 1'b0;
        start_frame(6'd8, 1'b1);
        for (int c = 0; c < 29; c++) tick();
        check("mid_pre_edge",    edge_count,  5);
        check("mid_pre_bit",     bit_count,   3);
        check("mid_pre_sampled", sampled_bit, 0);
        #2 RST = 1'b0;
        #1;
        check("mid_rst_edge",    edge_count,    0);
        check("mid_rst_bit",     bit_count,     0);
        check("mid_rst_sampled", sampled_bit,   1);
        check("mid_rst_done",    sampling_done, 0);
        edge_bit_en = 1'b0;
        #1 RST = 1'b1;
        tick(); tick();
        check("post_rst_edge", edge_count, 0);
        check("post_rst_bit",  bit_count,  0);

        // Glitch vote at P=16: H=8, votes taken from cycles 7, 8, 9 of a bit
        start_frame(6'd16, 1'b1);
        for (int c = 0; c < 32; c++) begin
            RX_IN = (c == 8 || c == 23 || c == 24) ? 1'b1 : 1'b0;
            if (c == 9)  check("glt_nodone", sampling_done, 0);
            if (c == 10) begin
                check("glt1_done",    sampling_done, 1);
                check("glt1_sampled", sampled_bit,   0);
            end
            if (c == 26) begin
                check("glt2_done",    sampling_done, 1);
                check("glt2_sampled", sampled_bit,   1);
            end
            tick();
        end

        // Prescale change mid-frame is ignored until edge_bit_en drops
        RX_IN = 1'b1;
        start_frame(6'd8, 1'b0);
        for (int c = 0; c < 41; c++) begin
            if (c == 32) Prescale = 6'd32;
            if (c == 39) check("ps_hold_edge7", edge_count, 7);
            if (c == 40) begin
                check("ps_hold_edge0", edge_count, 0);
                check("ps_hold_bit5",  bit_count,  5);
            end
            tick();
        end
        start_frame(6'd32, 1'b0);
        for (int c = 0; c < 33; c++) begin
            if (c == 31) begin
                check("ps32_edge31", edge_count, 31);
                check("ps32_bit0",   bit_count,  0);
            end
            if (c == 32) begin
                check("ps32_edge0", edge_count, 0);
                check("ps32_bit1",  bit_count,  1);
            end
            tick();
        end
        start_frame(6'd12, 1'b0);
        for (int c = 0; c < 9; c++) begin
            if (c == 7) check("ps12_edge7", edge_count, 7);
            if (c == 8) begin
                check("ps12_edge0", edge_count, 0);
                check("ps12_bit1",  bit_count,  1);
            end
            tick();
        end

        // Counters run with sampling disabled: no strobe
        start_frame(6'd8, 1'b0);
        RX_IN = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (c == 6) begin
                check("nosam_done",    sampling_done, 0);
                check("nosam_sampled", sampled_bit,   1);
            end
            tick();
        end

        // Saturation at 15, then a single-cycle clear
        start_frame(6'd8, 1'b0);
        for (int c = 0; c < 163; c++) begin
            if (c == 120) check("sat_bit120", bit_count, 15);
            if (c == 159) check("sat_bit159", bit_count, 15);
            tick();
        end
        check("sat_edge3", edge_count, 3);
        check("sat_bit",   bit_count,  15);
        edge_bit_en = 1'b0;
        tick();
        check("clr_edge", edge_count, 0);
        check("clr_bit",  bit_count,  0);

        // Drop dat_sam_en at edge_count=H+1 in bit 1
        RX_IN = 1'b0;
        start_frame(6'd8, 1'b1);
        for (int c = 0; c < 14; c++) begin
            if (c == 7)  check("dse_pre_sampled", sampled_bit, 0);
            if (c == 13) dat_sam_en = 1'b0;
            tick();
        end
        check("dse_done",    sampling_done, 0);
        check("dse_sampled", sampled_bit,   1);

        // Drop edge_bit_en at edge_count=H+1: clear wins, no strobe
        start_frame(6'd8, 1'b1);
        for (int c = 0; c < 5; c++) tick();
        check("ebe_pre_edge", edge_count, 5);
        edge_bit_en = 1'b0;
        tick();
        check("ebe_done", sampling_done, 0);
        check("ebe_edge", edge_count,    0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

Oversampling front end of the UART receiver. It counts clock edges within each bit period and counts bits within a frame. At mid-bit it takes three samples of the serial line, majority-votes them and strobes the result. It sits directly upstream of the UART RX FSM: it consumes the FSM's `edge_bit_en` and `dat_sam_en`, and returns `edge_count`, `bit_count`, `sampled_bit` and `sampling_done`.

## Interface
- `FALLBACK_PRESCALE`, default 8: prescale used when `Prescale` holds an illegal value.
- `CLK`  in  1  system clock; all state updates on its rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `RX_IN`  in  1  serial line, already synchronised to `CLK` by the top-level synchroniser.
- `Prescale`  in  6  oversampling ratio; legal values are 8, 16 and 32.
- `edge_bit_en`  in  1  from the FSM; enables the edge and bit counters.
- `dat_sam_en`  in  1  from the FSM; enables sampling.
- `edge_count`  out  6  clock edges elapsed within the current bit, 0..P-1.
- `bit_count`  out  4  bit periods completed in the current frame.
- `sampled_bit`  out  1  majority-voted value of the last sampled bit.
- `sampling_done`  out  1  one-cycle strobe; `sampled_bit` is valid while it is high.

## Operation
- Prescale latch, `prescale_q`:
  - Loaded every cycle while `edge_bit_en`=0; frozen while `edge_bit_en`=1, so mid-frame changes are ignored.
  - Values other than 8/16/32 load `FALLBACK_PRESCALE`.
  - Below, P = `prescale_q` and H = P/2.
- Edge counter:
  - `edge_bit_en`=1: increments each cycle; at P-1 it wraps to 0.
  - `edge_bit_en`=0: synchronously cleared to 0.
- Bit counter:
  - Increments on the same edge that `edge_count` wraps P-1 -> 0.
  - Saturates at 15; no wrap.
  - Synchronously cleared while `edge_bit_en`=0.
- Sampler, active only while `dat_sam_en`=1:
  - s0 <= `RX_IN` at the edge ending the cycle with `edge_count`=H-1.
  - s1 <= `RX_IN` at the edge ending the cycle with `edge_count`=H.
  - At the edge ending the cycle with `edge_count`=H+1: `sampled_bit` <= majority(s0, s1, `RX_IN`) and `sampling_done` <= 1.
  - `sampling_done` is forced back to 0 on the next edge, giving exactly one strobe per bit period.
- `dat_sam_en`=0: s0, s1 and `sampling_done` clear to 0; `sampled_bit` is forced to 1 (idle line level).
- Simultaneous events:
  - `edge_bit_en` falling while `sampling_done` is due: the clear wins and no strobe is produced.
  - `edge_bit_en`=1 with `dat_sam_en`=0: the counters run but no samples are taken.
- Reset, asserted at any time including mid-frame:
  - `edge_count`=0, `bit_count`=0, `sampling_done`=0, `sampled_bit`=1, s0=s1=0.
  - `prescale_q`=`FALLBACK_PRESCALE`.
  - After release the block behaves as though `edge_bit_en` had just been 0.

## Timing
- Cycle k is the first cycle with `edge_bit_en`=1; `edge_count`=0 in cycle k.
  - `edge_count`=j in cycle k+j.
  - `bit_count` becomes 1 in cycle k+P.
- Within bit n (n from 0), `sampling_done` is high only in cycle k+nP+H+2. For P=8 that is `edge_count`=6, which keeps the strobe inside the bit because H+2 < P for every legal P.
- The FSM sees `bit_count`=1 at the start of bit 1 and uses it to leave START.
  - It sees `bit_count`=9 at the first edge of the bit after data bit 7, i.e. parity or stop.
  - When the FSM drops `edge_bit_en` for one cycle at the end of STOP (back-to-back frame), both counters are 0 in the following cycle and a new `prescale_q` is latched.
- No combinational path from any input to any output; all outputs are registered.

## Test plan
- Reset: assert `RST`=0 mid-frame with `edge_count`=5 and `bit_count`=3 -> all outputs take reset values immediately, before any clock edge; after release the counters stay at 0 while `edge_bit_en`=0.
- Frame at P=8: send 0xA5 LSB-first with start bit, parity and stop, holding both enables high -> `sampling_done` high whenever `edge_count`=6, with `sampled_bit` values 0,1,0,1,0,0,1,0,1,p,1; `bit_count` reaches 11 after 88 cycles.
- Glitch vote at P=16: force `RX_IN` to 1 for the single cycle with `edge_count`=8 inside a 0 bit -> `sampled_bit`=0; force it to 1 for cycles 7 and 8 -> `sampled_bit`=1.
- Prescale handling: change `Prescale` from 8 to 32 at `bit_count`=4 -> the bit period stays 8 until `edge_bit_en` drops, then becomes 32. Apply `Prescale`=12 -> the period is 8 cycles.
- Saturation and clear: hold `edge_bit_en`=1 for 20 bit periods at P=8 -> `bit_count` holds at 15. Drop `edge_bit_en` for 1 cycle -> both counters read 0 in the next cycle.
- Enable edge cases: drop `dat_sam_en` at `edge_count`=H+1 -> no strobe and `sampled_bit`=1. Drop `edge_bit_en` at `edge_count`=H+1 -> no strobe.
